me_unit: RTL and testbench



---
 rtl/pipe_pkg.sv | 46 ++++
 rtl/me_rdata_hold.sv | 35 +++
 rtl/me_unit.sv | 70 +++++++
 tb/tb_me_unit.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared widths and field positions for the EX->ME and ME->WB pipeline buses.
package pipe_pkg;

  localparam int EX_ME_BUS_W = 71;
  localparam int ME_WB_BUS_W = 70;

  // EX->ME bus: {pc, alu_result, res_from_mem, gr_we, dest}
  localparam int EX_PC_MSB   = 70;
  localparam int EX_PC_LSB   = 39;
  localparam int EX_ALU_MSB  = 38;
  localparam int EX_ALU_LSB  = 7;
  localparam int EX_MEM_BIT  = 6;
  localparam int EX_WE_BIT   = 5;
  localparam int EX_DEST_MSB = 4;
  localparam int EX_DEST_LSB = 0;

  // ME->WB bus: {pc, final_result, gr_we, dest}
  localparam int WB_PC_MSB   = 69;
  localparam int WB_PC_LSB   = 38;
  localparam int WB_RES_MSB  = 37;
  localparam int WB_RES_LSB  = 6;
  localparam int WB_WE_BIT   = 5;
  localparam int WB_DEST_MSB = 4;
  localparam int WB_DEST_LSB = 0;

  localparam logic [EX_ME_BUS_W-1:0] EX_ME_BUS_ZERO = '0;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] alu_result;
    logic        res_from_mem;
    logic        gr_we;
    logic [4:0]  dest;
  } ex_me_fields_t;

  function automatic ex_me_fields_t unpack_ex_me(input logic [EX_ME_BUS_W-1:0] bus);
    ex_me_fields_t f;
    f.pc           = bus[EX_PC_MSB:EX_PC_LSB];
    f.alu_result   = bus[EX_ALU_MSB:EX_ALU_LSB];
    f.res_from_mem = bus[EX_MEM_BIT];
    f.gr_we        = bus[EX_WE_BIT];
    f.dest         = bus[EX_DEST_MSB:EX_DEST_LSB];
    return f;
  endfunction

endpackage

// File: rtl/me_rdata_hold.sv
// Keeps the one-cycle SRAM read response alive while WB stalls the instruction in ME.
module me_rdata_hold (
  input  logic        clk,
  input  logic        reset,
  input  logic        accept,
  input  logic        me_valid,
  input  logic        wb_allow_in,
  input  logic [31:0] data_sram_rdata,
  output logic [31:0] load_data
);

  logic        first_cycle_reg;
  logic        hold_valid_reg;
  logic [31:0] rdata_hold_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      first_cycle_reg <= 1'b0;
      hold_valid_reg  <= 1'b0;
      rdata_hold_reg  <= 32'h0;
    end else begin
      first_cycle_reg <= accept;
      // A fresh instruction always starts reading the live SRAM port.
      if (accept) begin
        hold_valid_reg <= 1'b0;
      end else if (first_cycle_reg && me_valid && !wb_allow_in) begin
        rdata_hold_reg <= data_sram_rdata;
        hold_valid_reg <= 1'b1;
      end
    end
  end

  assign load_data = hold_valid_reg ? rdata_hold_reg : data_sram_rdata;

endmodule

// File: rtl/me_unit.sv
// Memory-access pipeline stage: EX->ME handshake, load result selection and forwarding to ID.
module me_unit
  import pipe_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   EX_to_ME_Valid,
  input  logic [EX_ME_BUS_W-1:0] EX_to_ME_Bus,
  output logic                   ME_Allow_in,
  input  logic [31:0]            data_sram_rdata,
  input  logic                   WB_Allow_in,
  output logic                   ME_to_WB_Valid,
  output logic [ME_WB_BUS_W-1:0] ME_to_WB_Bus,
  output logic [4:0]             ME_dest,
  output logic [31:0]            ME_Forward_Res
);

  localparam logic ME_READY_GO = 1'b1;

  logic                   me_valid_reg;
  logic [EX_ME_BUS_W-1:0] bus_reg;
  ex_me_fields_t          fields;
  logic                   accept;
  logic [31:0]            load_data;
  logic [31:0]            final_result;

  assign ME_Allow_in    = !me_valid_reg || (ME_READY_GO && WB_Allow_in);
  assign ME_to_WB_Valid = me_valid_reg && ME_READY_GO;
  assign accept         = ME_Allow_in && EX_to_ME_Valid;

  always_ff @(posedge clk) begin
    if (reset) begin
      me_valid_reg <= 1'b0;
      bus_reg      <= EX_ME_BUS_ZERO;
    end else begin
      if (ME_Allow_in) begin
        me_valid_reg <= EX_to_ME_Valid;
      end
      if (accept) begin
        bus_reg <= EX_to_ME_Bus;
      end
    end
  end

  assign fields = unpack_ex_me(bus_reg);

  me_rdata_hold u_rdata_hold (
    .clk             (clk),
    .reset           (reset),
    .accept          (accept),
    .me_valid        (me_valid_reg),
    .wb_allow_in     (WB_Allow_in),
    .data_sram_rdata (data_sram_rdata),
    .load_data       (load_data)
  );

  assign final_result = fields.res_from_mem ? load_data : fields.alu_result;

  always_comb begin
    ME_to_WB_Bus = '0;
    ME_to_WB_Bus[WB_PC_MSB:WB_PC_LSB]     = fields.pc;
    ME_to_WB_Bus[WB_RES_MSB:WB_RES_LSB]   = final_result;
    ME_to_WB_Bus[WB_WE_BIT]               = fields.gr_we;
    ME_to_WB_Bus[WB_DEST_MSB:WB_DEST_LSB] = fields.dest;
  end

  assign ME_dest        = fields.dest & {5{me_valid_reg}};
  assign ME_Forward_Res = final_result;

endmodule

// File: tb/tb_me_unit.sv
// Scoreboard bench for me_unit: directed scenarios followed by randomized traffic.
module tb_me_unit;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] alu;
    bit          mem;
    bit          we;
    logic [4:0]  dest;
    logic [31:0] ldv;
  } item_t;

  logic        clk;
  logic        reset;
  logic        EX_to_ME_Valid;
  logic [70:0] EX_to_ME_Bus;
  logic        ME_Allow_in;
  logic [31:0] data_sram_rdata;
  logic        WB_Allow_in;
  logic        ME_to_WB_Valid;
  logic [69:0] ME_to_WB_Bus;
  logic [4:0]  ME_dest;
  logic [31:0] ME_Forward_Res;

  me_unit dut (
    .clk             (clk),
    .reset           (reset),
    .EX_to_ME_Valid  (EX_to_ME_Valid),
    .EX_to_ME_Bus    (EX_to_ME_Bus),
    .ME_Allow_in     (ME_Allow_in),
    .data_sram_rdata (data_sram_rdata),
    .WB_Allow_in     (WB_Allow_in),
    .ME_to_WB_Valid  (ME_to_WB_Valid),
    .ME_to_WB_Bus    (ME_to_WB_Bus),
    .ME_dest         (ME_dest),
    .ME_Forward_Res  (ME_Forward_Res)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  item_t       q[$];
  int          vectors = 0;
  int          miscompares = 0;
  bit          mon_on = 0;
  bit          pristine = 0;
  bit          just_acc = 0;
  logic [31:0] last_ldv = 32'h0;

  function automatic logic [31:0] exp_res(input item_t it);
    return it.mem ? it.ldv : it.alu;
  endfunction

  function automatic item_t mk(input logic [31:0] pc, input logic [31:0] alu, input bit mem,
                               input bit we, input logic [4:0] dest, input logic [31:0] ldv);
    item_t it;
    it.pc = pc; it.alu = alu; it.mem = mem; it.we = we; it.dest = dest; it.ldv = ldv;
    return it;
  endfunction

  function automatic item_t rnd_item();
    return mk($urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              5'($urandom_range(0, 31)), $urandom);
  endfunction

  task automatic check(input string name, input logic [69:0] act, input logic [69:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %h, want %h", name, $time, act, exp);
    end
  endtask

  // Monitor: the queue holds at most the instruction the model believes is sitting in ME.
  always @(negedge clk) begin : monitor
    bit ev;
    if (mon_on) begin
      ev = (q.size() != 0);
      check("valid", 70'(ME_to_WB_Valid), 70'(ev));
      check("allow_in", 70'(ME_Allow_in), 70'(!ev || WB_Allow_in));
      check("me_dest", 70'(ME_dest), ev ? 70'(q[0].dest) : 70'(0));
      if (ev) begin
        check("forward", 70'(ME_Forward_Res), 70'(exp_res(q[0])));
        check("wb_bus", ME_to_WB_Bus, {q[0].pc, exp_res(q[0]), q[0].we, q[0].dest});
        $display("ME out pc=%h res=%h we=%0d dest=%0d wb_allow=%0d",
                 q[0].pc, exp_res(q[0]), q[0].we, q[0].dest, WB_Allow_in);
        if (WB_Allow_in) void'(q.pop_front());
      end else if (pristine) begin
        check("reset_bus", ME_to_WB_Bus, 70'(0));
      end
    end
  end

  // One clock of stimulus; rdata carries the load value only in the first ME cycle.
  task automatic step(input bit v, input item_t it, input bit wb, input bit r);
    bit acc;
    EX_to_ME_Valid  = v;
    EX_to_ME_Bus    = {it.pc, it.alu, it.mem, it.we, it.dest};
    WB_Allow_in     = wb;
    reset           = r;
    data_sram_rdata = just_acc ? last_ldv : $urandom;
    acc = !r && v && (q.size() == 0 || wb);
    @(posedge clk);
    if (r) begin
      q.delete();
      pristine = 1;
      mon_on   = 1;
      just_acc = 0;
    end else begin
      just_acc = acc;
      if (acc) begin
        q.push_back(it);
        last_ldv = it.ldv;
        pristine = 0;
      end
    end
    #1;
  endtask

  item_t idle;

  initial begin
    idle = mk(32'h0, 32'h0, 0, 0, 5'd0, 32'h0);
    // reset with EX offering an instruction
    step(1, mk(32'h1c00_0100, 32'haaaa_aaaa, 0, 1, 5'd3, 32'h0), 1, 1);
    step(1, mk(32'h1c00_0100, 32'haaaa_aaaa, 0, 1, 5'd3, 32'h0), 1, 1);
    // ALU passthrough
    step(1, mk(32'h1c00_0000, 32'h1234_5678, 0, 1, 5'd5, 32'h5555_0000), 1, 0);
    step(0, idle, 1, 0);
    // load, no stall
    step(1, mk(32'h1c00_0004, 32'h0000_1000, 1, 1, 5'd7, 32'hdead_beef), 1, 0);
    step(0, idle, 1, 0);
    // load under a 3-cycle stall, EX keeps offering a different instruction
    step(1, mk(32'h1c00_0008, 32'h0000_2000, 1, 1, 5'd9, 32'hcafe_f00d), 1, 0);
    for (int i = 0; i < 3; i++)
      step(1, mk(32'h1c00_0f00, 32'h7777_7777, 0, 1, 5'd30, 32'h0), 0, 0);
    step(0, idle, 1, 0);
    // back-to-back, alternating load/ALU
    for (int i = 0; i < 4; i++)
      step(1, mk(32'h1c00_0010 + 32'(4 * i), 32'h100 + 32'(i), 1'(i % 2 == 0), 1,
                 5'(10 + i), 32'hbeef_0000 + 32'(i)), 1, 0);
    step(0, idle, 1, 0);
    // reset in the middle of a held-load stall
    step(1, mk(32'h1c00_0040, 32'h0, 1, 1, 5'd12, 32'h2222_2222), 1, 0);
    step(0, idle, 0, 0);
    step(0, idle, 0, 1);
    step(1, mk(32'h1c00_0044, 32'h0, 1, 1, 5'd13, 32'h1111_1111), 1, 0);
    step(0, idle, 1, 0);
    // randomized traffic with occasional reset
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 3) != 0, rnd_item(), $urandom_range(0, 3) != 0,
           $urandom_range(0, 99) == 0);
    for (int i = 0; i < 3; i++) step(0, idle, 1, 0);
    @(negedge clk);
    #1;
    check("drained", 70'(q.size()), 70'(0));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
